external_interrupt_controller: RTL and testbench

Prioritizes up to NUM_SRC peripheral interrupt lines and feeds the core interrupt unit one request at a time. Each request carries its source ID, and the block waits for the core's toggle acknowledge before it issues the next one. It sits on the EIC side of the core interrupt unit and drives the level request line, which the core synchronizes and edge-detects. Because of that, the block holds the ID stable for the whole service and guarantees a minimum low gap on the request line between consecutive requests.

---
 rtl/eic_pkg.sv | 15 +
 rtl/eic_priority_picker.sv | 30 +++
 rtl/external_interrupt_controller.sv | 123 ++++++++++++
 tb/tb_external_interrupt_controller.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/eic_pkg.sv
// Shared types and defaults for the external interrupt controller.
package eic_pkg;

  localparam int NUM_SRC_DEF = 8;
  localparam int ID_W_DEF    = 3;
  localparam int REQ_GAP_DEF = 4;
  localparam int MIN_REQ_GAP = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    GAP  = 2'd2
  } eicState_t;

endpackage

// File: rtl/eic_priority_picker.sv
// Combinational picker: first set bit of reqVec searching upward from startIdx, wrapping.
module eic_priority_picker
  import eic_pkg::*;
#(
  parameter int NUM_SRC = NUM_SRC_DEF,
  parameter int ID_W    = ID_W_DEF
) (
  input  logic [NUM_SRC-1:0] reqVec,
  input  logic [ID_W-1:0]    startIdx,
  output logic               pickVld,
  output logic [ID_W-1:0]    pickIdx
);

  int pos;

  always_comb begin
    pickVld = 1'b0;
    pickIdx = '0;
    pos     = 0;
    for (int i = 0; i < NUM_SRC; i++) begin
      pos = int'(startIdx) + i;
      if (pos >= NUM_SRC) pos = pos - NUM_SRC;
      if (!pickVld && reqVec[pos]) begin
        pickVld = 1'b1;
        pickIdx = ID_W'(pos);
      end
    end
  end

endmodule

// File: rtl/external_interrupt_controller.sv
// Serializes edge-captured sources into one toggle-acked request at a time to the core.
// Defining EIC_ROUND_ROBIN_EN selects round-robin priority instead of fixed lowest-index-first.
module external_interrupt_controller
  import eic_pkg::*;
#(
  parameter int NUM_SRC = NUM_SRC_DEF,
  parameter int ID_W    = ID_W_DEF,
  parameter int REQ_GAP = REQ_GAP_DEF
) (
  input  logic               Sys_Clock,
  input  logic               Sys_Reset,
  input  logic [NUM_SRC-1:0] Src_Irq,
  input  logic               EIC_IntAck,
  output logic               EIC_IntReq,
  output logic [ID_W-1:0]    EIC_IntId,
  output logic [NUM_SRC-1:0] Pending,
  output logic               Busy
);

  localparam int GAP_W = (REQ_GAP > 2) ? $clog2(REQ_GAP) : 1;

  if (REQ_GAP < MIN_REQ_GAP) begin : gReqGapCheck
    $error("REQ_GAP must be at least %0d", MIN_REQ_GAP);
  end
  if (ID_W != $clog2(NUM_SRC)) begin : gIdWidthCheck
    $error("ID_W must equal clog2(NUM_SRC)");
  end
  if (NUM_SRC < 2 || NUM_SRC > 32) begin : gNumSrcCheck
    $error("NUM_SRC must be within 2..32");
  end

  eicState_t          state;
  logic [GAP_W-1:0]   gapCnt;
  logic [NUM_SRC-1:0] srcLast;
  logic [NUM_SRC-1:0] srcRise;
  logic [NUM_SRC-1:0] clrVec;
  logic               ackMeta;
  logic               ackSync;
  logic               ackLast;
  logic               ackEvent;
  logic               pickVld;
  logic [ID_W-1:0]    pickIdx;
  logic [ID_W-1:0]    startIdx;

  assign srcRise  = Src_Irq & ~srcLast;
  assign ackEvent = ackSync ^ ackLast;
  assign Busy     = (state == REQ);

  always_comb begin
    clrVec = '0;
    if (state == REQ && ackEvent) clrVec[EIC_IntId] = 1'b1;
  end

`ifdef EIC_ROUND_ROBIN_EN
  logic [ID_W-1:0] rrPtr;

  always_ff @(posedge Sys_Clock) begin
    if (Sys_Reset) begin
      rrPtr <= ID_W'(NUM_SRC - 1);
    end else if (state == IDLE && pickVld) begin
      rrPtr <= pickIdx;
    end
  end

  assign startIdx = (rrPtr == ID_W'(NUM_SRC - 1)) ? '0 : rrPtr + ID_W'(1);
`else
  assign startIdx = '0;
`endif

  eic_priority_picker #(
    .NUM_SRC (NUM_SRC),
    .ID_W    (ID_W)
  ) uPicker (
    .reqVec   (Pending),
    .startIdx (startIdx),
    .pickVld  (pickVld),
    .pickIdx  (pickIdx)
  );

  // Reset lands in GAP so a stale ack level settling through the synchronizer is discarded.
  always_ff @(posedge Sys_Clock) begin
    if (Sys_Reset) begin
      state      <= GAP;
      gapCnt     <= GAP_W'(REQ_GAP - 1);
      EIC_IntReq <= 1'b0;
      EIC_IntId  <= '0;
      Pending    <= '0;
      srcLast    <= '0;
      ackMeta    <= 1'b0;
      ackSync    <= 1'b0;
      ackLast    <= 1'b0;
    end else begin
      srcLast <= Src_Irq;
      ackMeta <= EIC_IntAck;
      ackSync <= ackMeta;
      ackLast <= ackSync;
      // A new edge in the same cycle as the clear keeps the source pending.
      Pending <= (Pending & ~clrVec) | srcRise;
      case (state)
        IDLE: begin
          if (pickVld) begin
            state      <= REQ;
            EIC_IntReq <= 1'b1;
            EIC_IntId  <= pickIdx;
          end
        end
        REQ: begin
          if (ackEvent) begin
            state      <= GAP;
            EIC_IntReq <= 1'b0;
            gapCnt     <= GAP_W'(REQ_GAP - 1);
          end
        end
        GAP: begin
          if (gapCnt == '0) state <= IDLE;
          else gapCnt <= gapCnt - GAP_W'(1);
        end
        default: state <= GAP;
      endcase
    end
  end

endmodule

// File: tb/tb_external_interrupt_controller.sv
// Self-checking bench: table of source patterns plus hand sequences, expected IDs via a scoreboard queue.
module tb_external_interrupt_controller;

  localparam int NUM_SRC = 8;
  localparam int ID_W    = 3;
  localparam int REQ_GAP = 4;

  logic               Sys_Clock;
  logic               Sys_Reset;
  logic [NUM_SRC-1:0] Src_Irq;
  logic               EIC_IntAck;
  logic               EIC_IntReq;
  logic [ID_W-1:0]    EIC_IntId;
  logic [NUM_SRC-1:0] Pending;
  logic               Busy;

  external_interrupt_controller #(
    .NUM_SRC (NUM_SRC),
    .ID_W    (ID_W),
    .REQ_GAP (REQ_GAP)
  ) dut (
    .Sys_Clock  (Sys_Clock),
    .Sys_Reset  (Sys_Reset),
    .Src_Irq    (Src_Irq),
    .EIC_IntAck (EIC_IntAck),
    .EIC_IntReq (EIC_IntReq),
    .EIC_IntId  (EIC_IntId),
    .Pending    (Pending),
    .Busy       (Busy)
  );

  typedef struct {
    logic [7:0] mask;
    logic [7:0] expPend;
  } vec_t;

  vec_t       vecs[4];
  logic [2:0] expQ[$];
  int         checks  = 0;
  int         errors  = 0;
  int         lastLat = 3;
  logic [2:0] lastExp = '0;
  logic       ackLvl  = 1'b0;
`ifdef EIC_ROUND_ROBIN_EN
  int         modelPtr = NUM_SRC - 1;
`endif

  initial Sys_Clock = 1'b0;
  always #5 Sys_Clock = ~Sys_Clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge Sys_Clock);
    #1;
  endtask

  task automatic pulse(input logic [7:0] m);
    Src_Irq = m;
    tick();
    Src_Irq = '0;
  endtask

  task automatic toggleAck();
    ackLvl     = ~ackLvl;
    EIC_IntAck = ackLvl;
  endtask

  // Reference order in which the controller should grant the sources in m.
  function automatic void pushOrder(input logic [7:0] m);
    int s;
    int p;
`ifdef EIC_ROUND_ROBIN_EN
    s = (modelPtr + 1) % NUM_SRC;
`else
    s = 0;
`endif
    for (int i = 0; i < NUM_SRC; i++) begin
      p = (s + i) % NUM_SRC;
      if (m[p]) begin
        expQ.push_back(3'(p));
`ifdef EIC_ROUND_ROBIN_EN
        modelPtr = p;
`endif
      end
    end
  endfunction

  task automatic waitReq();
    int n;
    n = 0;
    while (EIC_IntReq !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    check("req_seen", EIC_IntReq, 1);
  endtask

  task automatic serviceOne(input int ackDelay, input bit ackInGap);
    int n;
    logic [2:0] id;
    bit ok;
    waitReq();
    if (EIC_IntReq !== 1'b1) return;
    if (expQ.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_underflow: request ID %0d with nothing expected", EIC_IntId);
      return;
    end
    id = expQ.pop_front();
    lastExp = id;
    check("req_id", EIC_IntId, id);
    check("busy_in_req", Busy, 1);
    ok = 1'b1;
    repeat (ackDelay) begin
      tick();
      if (EIC_IntReq !== 1'b1 || EIC_IntId !== id) ok = 1'b0;
    end
    check("req_held_until_ack", ok, 1);
    toggleAck();
    n = 0;
    while (EIC_IntReq === 1'b1 && n < 6) begin
      tick();
      n++;
    end
    check("ack_to_fall_2_or_3_edges", (n == 2 || n == 3), 1);
    if (n == 2 || n == 3) lastLat = n;
    check("pending_cleared", Pending[id], 0);
    check("busy_after_ack", Busy, 0);
    if (ackInGap) toggleAck();
    ok = 1'b1;
    for (int k = 0; k < REQ_GAP; k++) begin
      tick();
      if (EIC_IntReq !== 1'b0 || EIC_IntId !== id) ok = 1'b0;
    end
    check("gap_low_id_held", ok, 1);
  endtask

  initial begin
    int n;
    bit quiet;
    Sys_Reset  = 1'b1;
    Src_Irq    = '0;
    EIC_IntAck = 1'b0;
    vecs[0] = '{mask: 8'h44, expPend: 8'h44};  // sources 2 and 6 together: 2 first
    vecs[1] = '{mask: 8'h81, expPend: 8'h81};
    vecs[2] = '{mask: 8'h0A, expPend: 8'h0A};
    vecs[3] = '{mask: 8'h70, expPend: 8'h70};

    repeat (3) tick();
    check("rst_req", EIC_IntReq, 0);
    check("rst_id", EIC_IntId, 0);
    check("rst_pending", Pending, 0);
    check("rst_busy", Busy, 0);
    Sys_Reset = 1'b0;
    repeat (REQ_GAP + 2) tick();
    check("idle_no_req", EIC_IntReq, 0);

    // Single source 5, ack after 5 cycles.
    pushOrder(8'h20);
    pulse(8'h20);
    check("capture_pending", Pending, 8'h20);
    check("capture_no_req_yet", EIC_IntReq, 0);
    tick();
    check("req_one_cycle_after_capture", EIC_IntReq, 1);
    check("req_id5", EIC_IntId, 5);
    check("req_pending5", Pending, 8'h20);
    serviceOne(5, 1'b0);
    check("single_drained", Pending, 0);

    foreach (vecs[i]) begin
      pushOrder(vecs[i].mask);
      pulse(vecs[i].mask);
      check($sformatf("vec%0d_pending", i), Pending, vecs[i].expPend);
      for (int b = 0; b < $countones(vecs[i].mask); b++) serviceOne(3, 1'b0);
      check($sformatf("vec%0d_drained", i), Pending, 0);
    end

    // Ack toggles in GAP and in IDLE are discarded.
    pushOrder(8'h03);
    pulse(8'h03);
    serviceOne(2, 1'b1);
    serviceOne(5, 1'b0);
    toggleAck();
    repeat (5) tick();
    check("idle_ack_no_req", EIC_IntReq, 0);
    check("idle_ack_pending", Pending, 0);
    check("idle_ack_id_held", EIC_IntId, lastExp);

    // Source 4 re-rises on the very edge its ack is acted on.
    pushOrder(8'h10);
    pushOrder(8'h10);
    pulse(8'h10);
    waitReq();
    check("setclr_id", EIC_IntId, expQ.pop_front());
    toggleAck();
    repeat (lastLat - 1) tick();
    Src_Irq = 8'h10;
    tick();
    Src_Irq = '0;
    check("setclr_req_fell", EIC_IntReq, 0);
    check("setclr_pending_kept", Pending, 8'h10);
    n = 0;
    while (EIC_IntReq !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check("setclr_regap_cycles", n, REQ_GAP + 1);
    serviceOne(2, 1'b0);
    check("setclr_drained", Pending, 0);

    // Reset while ID 3 is in flight and ack is held high.
    pushOrder(8'h08);
    pulse(8'h08);
    waitReq();
    check("rstmid_id", EIC_IntId, expQ.pop_front());
    ackLvl     = 1'b1;
    EIC_IntAck = 1'b1;
    Sys_Reset  = 1'b1;
    tick();
    check("rstmid_req", EIC_IntReq, 0);
    check("rstmid_pending", Pending, 0);
    check("rstmid_busy", Busy, 0);
    Sys_Reset = 1'b0;
`ifdef EIC_ROUND_ROBIN_EN
    modelPtr = NUM_SRC - 1;
`endif
    quiet = 1'b1;
    repeat (REQ_GAP + 3) begin
      tick();
      if (EIC_IntReq !== 1'b0 || Pending !== '0) quiet = 1'b0;
    end
    check("rstmid_no_spurious", quiet, 1);
    pushOrder(8'h01);
    pulse(8'h01);
    serviceOne(2, 1'b0);
    check("rstmid_drained", Pending, 0);

`ifdef EIC_ROUND_ROBIN_EN
    expQ.push_back(3'd1);
    expQ.push_back(3'd3);
    expQ.push_back(3'd1);
    expQ.push_back(3'd3);
    pulse(8'h0A);
    serviceOne(2, 1'b0);
    pulse(8'h02);
    serviceOne(2, 1'b0);
    pulse(8'h08);
    serviceOne(2, 1'b0);
    serviceOne(2, 1'b0);
    modelPtr = 3;
    check("rr_drained", Pending, 0);
`endif

    check("scoreboard_empty", expQ.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
